// File: rtl/sram_arb_pkg.sv
// Shared types for the CPU/DMA SRAM arbiter: FSM state encoding and master IDs.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ACC = 3'd1,
    CPU_ACK = 3'd2,
    DMA_ACC = 3'd3,
    DMA_ACK = 3'd4
  } state_t;

  localparam logic CPU = 1'b0;
  localparam logic DMA = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational arbitration decision: round-robin on ties, with a bounded DMA lock.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic          last_grant,
  input  logic          dma_lock,
  input  logic [CW-1:0] burst_cnt,
  output logic          grant_valid,
  output logic          grant_id,
  output logic          lock_active
);

  // The lock only holds while DMA owns the bus and its burst budget is not spent.
  assign lock_active = dma_lock && (last_grant == DMA) && (burst_cnt < CW'(MAX_BURST));

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = CPU;
    if (cpu_req && dma_req) begin
      grant_valid = 1'b1;
      grant_id    = lock_active ? DMA : ~last_grant;
    end else if (cpu_req) begin
      grant_valid = 1'b1;
      grant_id    = CPU;
    end else if (dma_req) begin
      grant_valid = 1'b1;
      grant_id    = DMA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Serializes one-word CPU and DMA transactions onto the single-port SRAM.
// Handshake: a master holds req with a stable command until its one-cycle ack pulse.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  input  logic          dma_lock,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  output logic          sram_we,
  output logic          sram_re,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy,
  output state_t        dbg_state
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic [CW-1:0] burst_cnt;

  logic          pick_cpu_req;
  logic          pick_dma_req;
  logic          grant_valid;
  logic          grant_id;
  logic          lock_active;
  logic          grant_take;

  // The owner of the current ack is dropping req next cycle, so it never re-wins here.
  assign pick_cpu_req = cpu_req && (state != CPU_ACK);
  assign pick_dma_req = dma_req && (state != DMA_ACK);

  sram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_pick (
    .cpu_req     (pick_cpu_req),
    .dma_req     (pick_dma_req),
    .last_grant  (last_grant),
    .dma_lock    (dma_lock),
    .burst_cnt   (burst_cnt),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .lock_active (lock_active)
  );

  always_comb begin
    state_nxt  = state;
    grant_take = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          state_nxt  = (grant_id == DMA) ? DMA_ACC : CPU_ACC;
        end
      end
      CPU_ACC: state_nxt = CPU_ACK;
      DMA_ACC: state_nxt = DMA_ACK;
      CPU_ACK: begin
        // Only DMA can be granted here; handing over costs no idle cycle.
        if (grant_valid) begin
          grant_take = 1'b1;
          state_nxt  = DMA_ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      DMA_ACK: begin
        // A live lock keeps the CPU off the bus; DMA re-arbitrates through IDLE.
        if (grant_valid && !lock_active) begin
          grant_take = 1'b1;
          state_nxt  = CPU_ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= DMA;
      burst_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_take) begin
        last_grant <= grant_id;
      end
      if (!dma_lock) begin
        burst_cnt <= '0;
      end else if (grant_take) begin
        if (grant_id == CPU) begin
          burst_cnt <= '0;
        end else if (burst_cnt != CW'(MAX_BURST)) begin
          burst_cnt <= burst_cnt + CW'(1);
        end
      end
    end
  end

  // Strobes are qualified by rst so an access cut short by reset never touches the SRAM.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we    = 1'b0;
    sram_re    = 1'b0;
    case (state)
      CPU_ACC: begin
        sram_addr  = cpu_addr;
        sram_wdata = cpu_wdata;
        sram_we    = cpu_we & rst;
        sram_re    = ~cpu_we & rst;
      end
      DMA_ACC: begin
        sram_addr  = dma_addr;
        sram_wdata = dma_wdata;
        sram_we    = dma_we & rst;
        sram_re    = ~dma_we & rst;
      end
      default: ;
    endcase
  end

  assign cpu_ack   = (state == CPU_ACK);
  assign dma_ack   = (state == DMA_ACK);
  assign cpu_rdata = cpu_ack ? sram_rdata : '0;
  assign dma_rdata = dma_ack ? sram_rdata : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  a_acks_exclusive : assert property (@(posedge clk) disable iff (!rst) !(cpu_ack && dma_ack));
  a_strobes_exclusive : assert property (@(posedge clk) disable iff (!rst) !(sram_we && sram_re));
  a_idle_quiet : assert property (@(posedge clk) disable iff (!rst)
    (state == IDLE) |-> (!sram_we && !sram_re && !cpu_ack && !dma_ack));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table plus burst-lock and reset-abort sequences.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack, dma_lock;
  logic [7:0]  dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_we, sram_re, busy;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  sram_arbiter #(.AW(8), .DW(32), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .dma_ack    (dma_ack),
    .dma_lock   (dma_lock),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .sram_re    (sram_re),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // SRAM model with a bench-side load port for preloading
  logic [31:0] mem [64];
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (sram_we) mem[sram_addr[7:2]] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr[7:2]];
  end

  // scoreboard
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // vector table: inputs for one cycle and the outputs expected during that cycle
  typedef struct {
    logic        rst;
    logic [1:0]  c_rw;
    logic [7:0]  ca;
    logic [31:0] cd;
    logic [1:0]  d_rw;
    logic [7:0]  da;
    logic [31:0] dd;
    logic [4:0]  ctl;
    logic [7:0]  ea;
    logic [31:0] ew;
    logic [31:0] er;
  } vec_t;

  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b11;
  // {cpu_ack, dma_ack, sram_re, sram_we, busy}
  localparam logic [4:0] K_IDLE = 5'b00000;
  localparam logic [4:0] K_RE   = 5'b00101;
  localparam logic [4:0] K_WE   = 5'b00011;
  localparam logic [4:0] K_CACK = 5'b10001;
  localparam logic [4:0] K_DACK = 5'b01001;

  function automatic vec_t v(logic r, logic [1:0] c_rw, logic [7:0] ca, logic [31:0] cd,
                             logic [1:0] d_rw, logic [7:0] da, logic [31:0] dd,
                             logic [4:0] ctl, logic [7:0] ea, logic [31:0] ew, logic [31:0] er);
    vec_t t;
    t.rst = r; t.c_rw = c_rw; t.ca = ca; t.cd = cd;
    t.d_rw = d_rw; t.da = da; t.dd = dd;
    t.ctl = ctl; t.ea = ea; t.ew = ew; t.er = er;
    return t;
  endfunction

  // driver tasks
  task automatic drive_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    dma_lock = 0;
  endtask

  task automatic drive_vec(input vec_t t);
    rst = t.rst;
    cpu_req = t.c_rw[1]; cpu_we = t.c_rw[0]; cpu_addr = t.ca; cpu_wdata = t.cd;
    dma_req = t.d_rw[1]; dma_we = t.d_rw[0]; dma_addr = t.da; dma_wdata = t.dd;
    dma_lock = 1'b0;
  endtask

  function automatic logic [63:0] out_bus();
    return 64'({cpu_ack, dma_ack, sram_re, sram_we, busy, sram_addr, sram_wdata});
  endfunction

  vec_t vecs[$];

  initial begin
    logic [5:0]  pl_addr [3];
    logic [31:0] pl_data [3];
    int ci, di, cyc;
    logic [7:0] c_addr_l [2];
    logic [31:0] c_exp_l [2];

    // clock/reset block with SRAM preload
    rst = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    drive_idle();
    pl_addr[0] = 6'd32; pl_data[0] = 32'h0102_0304;
    pl_addr[1] = 6'd33; pl_data[1] = 32'hA5A5_0001;
    pl_addr[2] = 6'd34; pl_data[2] = 32'h0BAD_F00D;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = pl_addr[i]; ld_data = pl_data[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    #4;
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    check("reset_outputs", out_bus(), 64'd0);

    // single CPU read after reset
    vecs.push_back(v(0, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, NO, 8'h00, 0, K_RE,   8'h80, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, NO, 8'h00, 0, K_CACK, 8'h00, 0, 32'h0102_0304));
    vecs.push_back(v(1, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    // both request right after reset: CPU first, then DMA
    vecs.push_back(v(0, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_RE,   8'h80, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_CACK, 8'h00, 0, 32'h0102_0304));
    vecs.push_back(v(1, NO, 8'h00, 0, RD, 8'h84, 0, K_RE,   8'h84, 0, 0));
    vecs.push_back(v(1, NO, 8'h00, 0, RD, 8'h84, 0, K_DACK, 8'h00, 0, 32'hA5A5_0001));
    vecs.push_back(v(1, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    // DMA write then CPU read-back
    vecs.push_back(v(1, NO, 8'h00, 0, WR, 8'hC0, 32'hDEAD_BEEF, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, NO, 8'h00, 0, WR, 8'hC0, 32'hDEAD_BEEF, K_WE,   8'hC0, 32'hDEAD_BEEF, 0));
    vecs.push_back(v(1, NO, 8'h00, 0, WR, 8'hC0, 32'hDEAD_BEEF, K_DACK, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'hC0, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'hC0, 0, NO, 8'h00, 0, K_RE,   8'hC0, 0, 0));
    vecs.push_back(v(1, RD, 8'hC0, 0, NO, 8'h00, 0, K_CACK, 8'h00, 0, 32'hDEAD_BEEF));
    vecs.push_back(v(1, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    // continuous requests from both, no lock: C, D, C, D at one access per 2 cycles
    vecs.push_back(v(0, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_IDLE, 8'h00, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_RE,   8'h80, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_CACK, 8'h00, 0, 32'h0102_0304));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_RE,   8'h84, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_DACK, 8'h00, 0, 32'hA5A5_0001));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_RE,   8'h80, 0, 0));
    vecs.push_back(v(1, RD, 8'h80, 0, RD, 8'h84, 0, K_CACK, 8'h00, 0, 32'h0102_0304));
    vecs.push_back(v(1, NO, 8'h00, 0, RD, 8'h84, 0, K_RE,   8'h84, 0, 0));
    vecs.push_back(v(1, NO, 8'h00, 0, RD, 8'h84, 0, K_DACK, 8'h00, 0, 32'hA5A5_0001));
    vecs.push_back(v(1, NO, 8'h00, 0, NO, 8'h00, 0, K_IDLE, 8'h00, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #4;
      check($sformatf("vec%0d_out", i), out_bus(),
            64'({vecs[i].ctl, vecs[i].ea, vecs[i].ew}));
      if (vecs[i].ctl[4] && !vecs[i].c_rw[0])
        check($sformatf("vec%0d_cpu_rdata", i), 64'(cpu_rdata), 64'(vecs[i].er));
      if (vecs[i].ctl[3] && !vecs[i].d_rw[0])
        check($sformatf("vec%0d_dma_rdata", i), 64'(dma_rdata), 64'(vecs[i].er));
    end

    // DMA burst lock: 6 locked DMA writes against 2 CPU reads, MAX_BURST=4
    c_addr_l[0] = 8'h80; c_exp_l[0] = 32'h0102_0304;
    c_addr_l[1] = 8'h84; c_exp_l[1] = 32'hA5A5_0001;
    for (int k = 0; k < 4; k++) exp_q.push_back(DMA);
    exp_q.push_back(CPU);
    exp_q.push_back(DMA);
    exp_q.push_back(DMA);
    exp_q.push_back(CPU);
    ci = 0; di = 0; cyc = 0;
    while ((ci < 2 || di < 6) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rst = 1'b1;
      dma_lock = 1'b1;
      cpu_req = (ci < 2); cpu_we = 1'b0;
      cpu_addr = c_addr_l[ci < 2 ? ci : 1]; cpu_wdata = '0;
      dma_req = (di < 6); dma_we = 1'b1;
      dma_addr = 8'(di * 4); dma_wdata = 32'h100 + 32'(di);
      #4;
      if (cpu_ack && dma_ack) check("lock_acks_overlap", 64'(2'b11), 64'(2'b00));
      if (cpu_ack || dma_ack) begin
        if (exp_q.size() == 0) begin
          check("lock_ack_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          check($sformatf("lock_ack_order%0d", ci + di), 64'(dma_ack), 64'(exp_q.pop_front()));
        end
        if (cpu_ack) begin
          check($sformatf("lock_cpu_rdata%0d", ci), 64'(cpu_rdata), 64'(c_exp_l[ci]));
          ci++;
        end
        if (dma_ack) di++;
      end
    end
    check("lock_done_in_budget", 64'(cyc < 200), 64'd1);
    check("lock_queue_empty", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < 6; k++)
      check($sformatf("lock_mem%0d", k), 64'(mem[k]), 64'(32'h100 + 32'(k)));

    // reset during CPU_ACC of a write: no ack, SRAM unchanged, re-request completes
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h88; cpu_wdata = 32'h1234_5678;
    #4;
    check("abort_idle", out_bus(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("abort_no_ack", 64'({cpu_ack, dma_ack}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #4;
    check("abort_outputs_zero", out_bus(), 64'd0);
    check("abort_mem_unchanged", 64'(mem[34]), 64'(32'h0BAD_F00D));
    @(negedge clk);
    #4;
    check("rereq_write", out_bus(), 64'({K_WE, 8'h88, 32'h1234_5678}));
    @(negedge clk);
    #4;
    check("rereq_ack", out_bus(), 64'({K_CACK, 8'h00, 32'h0}));
    @(negedge clk);
    cpu_req = 1'b0;
    #4;
    check("rereq_idle", out_bus(), 64'd0);
    check("rereq_mem", 64'(mem[34]), 64'(32'h1234_5678));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
